// File: rtl/uart_mem_resp_tx_pkg.sv
// Shared definitions for the UART memory-response transmitter: byte FSM encodings,
// frame geometry and default baud divisor.
package uart_mem_resp_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam int UART_FRAME_W      = 42;
   localparam int UART_NBYTES       = 6;
   localparam int UART_CLKS_PER_BIT = 434;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/uart_mem_resp_tx_byte.sv
// One-byte UART serializer (start, 8 data LSB first, optional even parity, stop).
// Parity bit present only when UART_MEM_TX_PARITY_EN is defined.
module uart_mem_resp_tx_byte
   import uart_mem_resp_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_load,
   input  logic [7:0] i_byte,
   output logic       o_tx,
   output logic       o_last
);

   localparam int             BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   tx_state_t     r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
`ifdef UART_MEM_TX_PARITY_EN
   logic          r_par;
`endif
   logic          w_bit_end;

   assign w_bit_end = (r_baud == BAUD_MAX);
   assign o_last    = (r_state == ST_STOP) && w_bit_end;
   assign o_tx      = r_tx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
`ifdef UART_MEM_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_baud <= (r_state == ST_IDLE || w_bit_end) ? '0 : r_baud + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (i_load) begin
                  r_state <= ST_START;
                  r_shift <= i_byte;
                  r_tx    <= 1'b0;
`ifdef UART_MEM_TX_PARITY_EN
                  r_par   <= even_parity(i_byte);
`endif
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit == 3'd7) begin
`ifdef UART_MEM_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_tx    <= r_par;
`else
                     r_state <= ST_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= {1'b0, r_shift[7:1]};
                     r_tx    <= r_shift[1];
                  end
               end
            end
`ifdef UART_MEM_TX_PARITY_EN
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            ST_STOP: begin
               // A load in the last stop cycle chains the next start bit with no idle gap
               if (w_bit_end) begin
                  if (i_load) begin
                     r_state <= ST_START;
                     r_shift <= i_byte;
                     r_tx    <= 1'b0;
`ifdef UART_MEM_TX_PARITY_EN
                     r_par   <= even_parity(i_byte);
`endif
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_mem_resp_tx.sv
// Memory-response UART transmitter: serializes a zero-padded frame MSB byte first with a
// one-frame holding buffer and sticky overrun. Optional parity: UART_MEM_TX_PARITY_EN.
module uart_mem_resp_tx
   import uart_mem_resp_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FRAME_W      = UART_FRAME_W,
   parameter int NBYTES       = UART_NBYTES
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [FRAME_W-1:0] frame_in,
   input  logic               frame_valid,
   input  logic               clr_overrun,
   output logic               uart_tx,
   output logic               busy,
   output logic               frame_done,
   output logic               overrun
);

   localparam int              PAD_W    = NBYTES * 8;
   localparam int              IDX_W    = $clog2(NBYTES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES);

   logic [PAD_W-1:0]   r_shreg;
   logic [IDX_W-1:0]   r_idx;
   logic [FRAME_W-1:0] r_buf;
   logic               r_buf_full;
   logic               r_busy;
   logic               r_done;
   logic               r_overrun;

   logic               w_last;
   logic               w_frame_end;
   logic               w_load;
   logic               w_load_frame;
   logic [PAD_W-1:0]   w_load_pad;
   logic [7:0]         w_byte;
   logic               w_to_buf;
   logic               w_drop;

   assign w_frame_end = r_busy && w_last && (r_idx == IDX_LAST);
   assign w_to_buf    = r_busy && frame_valid && !w_frame_end && !r_buf_full;
   assign w_drop      = r_busy && frame_valid && !w_frame_end && r_buf_full;

   // A new frame starts either from idle or seamlessly at the end of the current frame,
   // taking the buffered frame ahead of one arriving in the same cycle.
   always_comb begin
      w_load_frame = 1'b0;
      w_load_pad   = '0;
      if (!r_busy) begin
         if (frame_valid) begin
            w_load_frame = 1'b1;
            w_load_pad   = PAD_W'(frame_in);
         end
      end else if (w_frame_end) begin
         if (r_buf_full) begin
            w_load_frame = 1'b1;
            w_load_pad   = PAD_W'(r_buf);
         end else if (frame_valid) begin
            w_load_frame = 1'b1;
            w_load_pad   = PAD_W'(frame_in);
         end
      end
      w_load = w_load_frame || (r_busy && w_last && !w_frame_end);
      w_byte = w_load_frame ? w_load_pad[PAD_W-1 -: 8] : r_shreg[PAD_W-1 -: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shreg    <= '0;
         r_idx      <= '0;
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_done <= w_frame_end;
         if (w_load_frame) begin
            r_shreg <= w_load_pad << 8;
            r_idx   <= IDX_W'(1);
            r_busy  <= 1'b1;
         end else if (w_load) begin
            r_shreg <= r_shreg << 8;
            r_idx   <= r_idx + 1'b1;
         end else if (w_frame_end) begin
            r_busy  <= 1'b0;
         end

         if (w_frame_end && r_buf_full) begin
            r_buf_full <= frame_valid;
            if (frame_valid) r_buf <= frame_in;
         end else if (w_to_buf) begin
            r_buf      <= frame_in;
            r_buf_full <= 1'b1;
         end

         r_overrun <= w_drop | (r_overrun & ~clr_overrun);
      end
   end

   assign busy       = r_busy;
   assign frame_done = r_done;
   assign overrun    = r_overrun;

   uart_mem_resp_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk    (clk),
      .reset_n(reset_n),
      .i_load (w_load),
      .i_byte (w_byte),
      .o_tx   (uart_tx),
      .o_last (w_last)
   );

endmodule

// File: tb/tb_uart_mem_resp_tx.sv
// Scoreboard bench for uart_mem_resp_tx at CLKS_PER_BIT=4; honours UART_MEM_TX_PARITY_EN.
module tb_uart_mem_resp_tx;

`ifdef UART_MEM_TX_PARITY_EN
   localparam int PB        = 1;
   localparam int BYTE_CYC  = 44;
   localparam int FRAME_CYC = 264;
`else
   localparam int PB        = 0;
   localparam int BYTE_CYC  = 40;
   localparam int FRAME_CYC = 240;
`endif
   localparam int STOP_POS = 38 + 4 * PB;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [41:0] frame_in;
   logic        frame_valid;
   logic        clr_overrun;
   logic        uart_tx;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_bytes[$];
   int         exp_start[$];
   int         exp_done[$];

   uart_mem_resp_tx #(.CLKS_PER_BIT(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_in   (frame_in),
      .frame_valid(frame_valid),
      .clr_overrun(clr_overrun),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end else begin
         $display("ok   %s: %0d (0x%0h) at cycle %0d", name, act, act, cyc);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected nothing at cycle %0d", name, act, act, cyc);
   endtask

   task automatic push_bytes(input logic [47:0] b);
      for (int i = 5; i >= 0; i--) exp_bytes.push_back(b[i*8 +: 8]);
   endtask

   // Caller is at posedge+1; the frame is consumed by the next posedge.
   task automatic pulse(input logic [41:0] f, input logic clr, output int acc);
      frame_in    = f;
      frame_valid = 1'b1;
      clr_overrun = clr;
      acc         = cyc + 1;
      @(posedge clk); #1;
      frame_valid = 1'b0;
      clr_overrun = 1'b0;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: decodes the line, checks frame_done timing, pops the scoreboard.
   initial begin : monitor
      bit         rx_active;
      int         rx_pos;
      int         rx_start;
      int         rx_idx;
      logic [7:0] rx_data;
      logic       rx_par;
      logic [7:0] e;
      int         ec;
      rx_active = 0; rx_pos = 0; rx_start = 0; rx_idx = 0; rx_data = '0; rx_par = 1'b0;
      forever begin
         @(negedge clk);
         if (reset_n !== 1'b1) begin
            rx_active = 0;
            rx_idx    = 0;
         end else begin
            if (frame_done === 1'b1) begin
               if (exp_done.size() == 0) unexpected("frame_done_extra", cyc);
               else begin
                  ec = exp_done.pop_front();
                  chk("frame_done_cycle", cyc, ec);
               end
            end
            if (!rx_active) begin
               if (uart_tx === 1'b0) begin
                  rx_active = 1;
                  rx_pos    = 0;
                  rx_start  = cyc;
               end
            end else begin
               rx_pos++;
            end
            if (rx_active) begin
               if (rx_pos == 2) chk("start_bit", uart_tx, 0);
               if (rx_pos >= 6 && rx_pos <= 34 && (rx_pos % 4) == 2)
                  rx_data[(rx_pos - 6) / 4] = uart_tx;
               if (PB == 1 && rx_pos == 38) rx_par = uart_tx;
               if (rx_pos == STOP_POS) begin
                  chk("stop_bit", uart_tx, 1);
                  if (exp_bytes.size() == 0) unexpected("byte_extra", rx_data);
                  else begin
                     e = exp_bytes.pop_front();
                     chk("byte", rx_data, e);
                     if (PB == 1) chk("parity_bit", rx_par, ^e);
                  end
                  if (rx_idx == 0) begin
                     if (exp_start.size() == 0) unexpected("frame_start_extra", rx_start);
                     else begin
                        ec = exp_start.pop_front();
                        chk("frame_start_cycle", rx_start, ec);
                     end
                  end
                  rx_idx = (rx_idx == 5) ? 0 : rx_idx + 1;
               end
               if (rx_pos == BYTE_CYC - 1) rx_active = 0;
            end
         end
      end
   end

   initial begin : stim
      int acc;
      int acc2;
      int dummy;
      int guard;
      reset_n     = 1'b0;
      frame_in    = '0;
      frame_valid = 1'b0;
      clr_overrun = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_uart_tx", uart_tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_overrun", overrun, 0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: single frame, latency and length
      push_bytes(48'h0005DEADBEEF);
      pulse(42'h005DEADBEEF, 1'b0, acc);
      exp_start.push_back(acc);
      exp_done.push_back(acc + FRAME_CYC);
      chk("t1_busy_after_accept", busy, 1);
      chk("t1_start_low", uart_tx, 0);
      wait_until(acc + FRAME_CYC + 3);
      chk("t1_busy_idle", busy, 0);
      chk("t1_line_idle", uart_tx, 1);

      // 2: back-to-back through the buffer
      push_bytes(48'h0005DEADBEEF);
      push_bytes(48'h03FF00000001);
      pulse(42'h005DEADBEEF, 1'b0, acc);
      exp_start.push_back(acc);
      exp_start.push_back(acc + FRAME_CYC);
      exp_done.push_back(acc + FRAME_CYC);
      exp_done.push_back(acc + 2 * FRAME_CYC);
      wait_until(acc + 2 * BYTE_CYC + 10);
      pulse(42'h3FF00000001, 1'b0, dummy);
      wait_until(acc + FRAME_CYC + 1);
      chk("t2_busy_between", busy, 1);
      wait_until(acc + 2 * FRAME_CYC + 3);
      chk("t2_overrun", overrun, 0);
      chk("t2_busy_idle", busy, 0);

      // 3: overrun; the drop coincides with clr_overrun so set must win
      push_bytes(48'h0005DEADBEEF);
      push_bytes(48'h03FF00000001);
      pulse(42'h005DEADBEEF, 1'b0, acc);
      exp_start.push_back(acc);
      exp_start.push_back(acc + FRAME_CYC);
      exp_done.push_back(acc + FRAME_CYC);
      exp_done.push_back(acc + 2 * FRAME_CYC);
      wait_until(acc + 20);
      pulse(42'h3FF00000001, 1'b0, dummy);
      chk("t3_no_overrun_yet", overrun, 0);
      wait_until(acc + 40);
      pulse(42'h12345678ABC, 1'b1, dummy);
      chk("t3_overrun_set_wins", overrun, 1);
      wait_until(acc + 2 * FRAME_CYC + 3);
      chk("t3_overrun_sticky", overrun, 1);
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      chk("t3_overrun_cleared", overrun, 0);

      // 4: reset during byte3 with a frame buffered
      push_bytes(48'h0005DEADBEEF);
      pulse(42'h005DEADBEEF, 1'b0, acc);
      exp_start.push_back(acc);
      wait_until(acc + 20);
      pulse(42'h3FF00000001, 1'b0, dummy);
      wait_until(acc + 3 * BYTE_CYC + 10);
      reset_n = 1'b0;
      #1;
      chk("t4_reset_line_high", uart_tx, 1);
      chk("t4_reset_busy", busy, 0);
      exp_bytes.delete();
      exp_start.delete();
      exp_done.delete();
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      push_bytes(48'h03FF00000001);
      pulse(42'h3FF00000001, 1'b0, acc);
      exp_start.push_back(acc);
      exp_done.push_back(acc + FRAME_CYC);
      wait_until(acc + FRAME_CYC + 3);
      chk("t4_busy_idle", busy, 0);

      // 5: new frame in the final stop cycle with the buffer empty
      push_bytes(48'h0005DEADBEEF);
      push_bytes(48'h03FF00000001);
      pulse(42'h005DEADBEEF, 1'b0, acc);
      exp_start.push_back(acc);
      exp_done.push_back(acc + FRAME_CYC);
      wait_until(acc + FRAME_CYC - 1);
      pulse(42'h3FF00000001, 1'b0, acc2);
      exp_start.push_back(acc2);
      exp_done.push_back(acc2 + FRAME_CYC);
      chk("t5_no_gap_accept", acc2, acc + FRAME_CYC);
      chk("t5_busy_held", busy, 1);
      wait_until(acc2 + FRAME_CYC + 3);
      chk("t5_busy_idle", busy, 0);

      guard = 0;
      while ((exp_bytes.size() + exp_done.size() + exp_start.size()) != 0 && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("left_bytes", exp_bytes.size(), 0);
      chk("left_done", exp_done.size(), 0);
      chk("left_start", exp_start.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
